// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM-like bus between the fetch and data ports,
// one outstanding transaction at a time, data first with a fetch starvation guard.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   inst_req/inst_addr       fetch request, held until inst_data_ok
//   inst_rdata/inst_data_ok  fetch read data and one-cycle completion pulse
//   data_req/wr/size/addr/wdata  load/store request, held until data_data_ok
//   data_rdata/data_data_ok  load data and one-cycle completion pulse
//   flush                    pipeline flush; makes an in-flight fetch stale
//   bus_req/wr/size/addr/wdata  master request towards the slave
//   bus_addr_ok/bus_data_ok/bus_rdata  slave handshakes and read data
//   stallreq_if/stallreq_mem per-stage stall requests for ctrl

module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic [DATA_W-1:0] inst_rdata,
   output logic              inst_data_ok,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_data_ok,
   input  logic              flush,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              stallreq_if,
   output logic              stallreq_mem
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   state_t state;
   state_t state_nx;

   // grant: 0 = fetch, 1 = data
   logic              grant;
   logic              discard;
   logic [1:0]        data_streak;
   logic              lat_wr;
   logic [1:0]        lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rdata_q;

   logic pick_data;
   logic pick_inst;
   logic take;

   // Data wins unless fetch has already lost twice in a row.
   // A fetch grant is withheld while flush is high: its address is stale.
   always_comb begin
      pick_data = data_req
                & ~(inst_req & (data_streak == 2'd2));
      pick_inst = inst_req & ~pick_data & ~flush;
      take      = pick_data | pick_inst;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (take) begin
               state_nx = S_ADDR;
            end
         end
         S_ADDR: begin
            if (bus_addr_ok) begin
               state_nx = S_DATA;
            end
         end
         S_DATA: begin
            if (bus_data_ok) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         grant       <= 1'b0;
         discard     <= 1'b0;
         data_streak <= 2'd0;
         rdata_q     <= '0;
         lat_wr      <= 1'b0;
         lat_size    <= 2'd0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (take) begin
                  grant <= pick_data;
                  if (pick_data) begin
                     lat_wr    <= data_wr;
                     lat_size  <= data_size;
                     lat_addr  <= data_addr;
                     lat_wdata <= data_wdata;
                     // pick_data with inst_req implies streak < 2,
                     // so the increment saturates by construction
                     if (inst_req) begin
                        data_streak <= data_streak + 2'd1;
                     end
                  end else begin
                     lat_wr      <= 1'b0;
                     lat_size    <= 2'd2;
                     lat_addr    <= inst_addr;
                     lat_wdata   <= '0;
                     data_streak <= 2'd0;
                  end
               end
            end
            S_ADDR: begin
               if (flush && !grant) begin
                  discard <= 1'b1;
               end
            end
            S_DATA: begin
               if (flush && !grant) begin
                  discard <= 1'b1;
               end
               if (bus_data_ok) begin
                  rdata_q <= bus_rdata;
               end
            end
            S_DONE: begin
               discard <= 1'b0;
            end
            default: begin
               discard <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      bus_req      = 1'b0;
      bus_wr       = 1'b0;
      bus_size     = 2'd0;
      bus_addr     = '0;
      bus_wdata    = '0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      unique case (state)
         S_ADDR: begin
            bus_req   = 1'b1;
            bus_wr    = lat_wr;
            bus_size  = lat_size;
            bus_addr  = lat_addr;
            bus_wdata = lat_wdata;
         end
         S_DONE: begin
            inst_data_ok = ~grant & ~discard;
            data_data_ok = grant;
         end
         default: begin
            bus_req = 1'b0;
         end
      endcase
   end

   assign inst_rdata   = rdata_q;
   assign data_rdata   = rdata_q;
   assign stallreq_if  = inst_req & ~inst_data_ok;
   assign stallreq_mem = data_req & ~data_data_ok;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against
// a transaction-timeline model of the arbiter.

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_data_ok;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_data_ok;
   logic        flush;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;
   logic        stallreq_if;
   logic        stallreq_mem;

   int checks = 0;
   int errors = 0;

   // slave model state
   int          s_aw = 0;
   int          s_dw = 0;
   int          s_cnt = 0;
   bit          s_ph = 1'b0;
   logic [31:0] s_rd = 32'h0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_rdata  (inst_rdata),
      .inst_data_ok(inst_data_ok),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_size   (data_size),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_rdata  (data_rdata),
      .data_data_ok(data_data_ok),
      .flush       (flush),
      .bus_req     (bus_req),
      .bus_wr      (bus_wr),
      .bus_size    (bus_size),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_addr_ok (bus_addr_ok),
      .bus_data_ok (bus_data_ok),
      .bus_rdata   (bus_rdata),
      .stallreq_if (stallreq_if),
      .stallreq_mem(stallreq_mem)
   );

   // Advance one cycle and play the slave: addr_ok after s_aw waits,
   // data_ok s_dw cycles after the cycle following addr_ok.
   task automatic step();
      @(posedge clk);
      #1;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (s_ph) begin
         if (s_cnt == s_dw) begin
            bus_data_ok = 1'b1;
            bus_rdata   = s_rd;
            s_ph        = 1'b0;
            s_cnt       = 0;
         end else begin
            s_cnt++;
         end
      end else if (bus_req === 1'b1) begin
         if (s_cnt == s_aw) begin
            bus_addr_ok = 1'b1;
            s_ph        = 1'b1;
            s_cnt       = 0;
         end else begin
            s_cnt++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_bus_req got %b want 0", bus_req);
      end
      checks++;
      if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
         errors++;
         $display("FAIL reset_ok got %b%b want 00", inst_data_ok, data_data_ok);
      end
      checks++;
      if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h/%h want 0", inst_rdata, data_rdata);
      end
      checks++;
      if (stallreq_if !== 1'b0 || stallreq_mem !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall got %b%b want 00", stallreq_if, stallreq_mem);
      end
      step();
      rst = 1'b1;
   endtask

   task automatic test_single_fetch();
      logic e_req, e_ok, e_sif;
      s_aw = 0;
      s_dw = 0;
      s_rd = 32'h2408_0001;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i == 0) begin
            inst_req  = 1'b1;
            inst_addr = 32'hBFC0_0000;
         end
         if (i == 4) inst_req = 1'b0;
         @(negedge clk);
         e_req = (i == 1);
         e_ok  = (i == 3);
         e_sif = (i <= 2);
         checks++;
         if (bus_req !== e_req) begin
            errors++;
            $display("FAIL fetch_bus_req c%0d got %b want %b", i, bus_req, e_req);
         end
         checks++;
         if (inst_data_ok !== e_ok) begin
            errors++;
            $display("FAIL fetch_ok c%0d got %b want %b", i, inst_data_ok, e_ok);
         end
         checks++;
         if (stallreq_if !== e_sif) begin
            errors++;
            $display("FAIL fetch_stall c%0d got %b want %b", i, stallreq_if, e_sif);
         end
         if (e_req) begin
            checks++;
            if (bus_addr !== 32'hBFC0_0000 || bus_wr !== 1'b0 || bus_size !== 2'd2) begin
               errors++;
               $display("FAIL fetch_fields got %h/%b/%0d want bfc00000/0/2", bus_addr, bus_wr, bus_size);
            end
         end
         if (e_ok) begin
            checks++;
            if (inst_rdata !== 32'h2408_0001) begin
               errors++;
               $display("FAIL fetch_rdata got %h want 24080001", inst_rdata);
            end
         end
      end
   endtask

   task automatic test_priority();
      logic e_req, e_iok, e_dok;
      s_aw = 0;
      s_dw = 0;
      s_rd = 32'h1111_2222;
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 0) begin
            inst_req   = 1'b1;
            inst_addr  = 32'hBFC0_0004;
            data_req   = 1'b1;
            data_wr    = 1'b1;
            data_size  = 2'd2;
            data_addr  = 32'h8000_1000;
            data_wdata = 32'hDEAD_BEEF;
         end
         if (i == 3) s_rd = 32'h8C02_0000;
         if (i == 4) data_req = 1'b0;
         if (i == 8) inst_req = 1'b0;
         @(negedge clk);
         e_req = (i == 1) || (i == 5);
         e_dok = (i == 3);
         e_iok = (i == 7);
         checks++;
         if (bus_req !== e_req) begin
            errors++;
            $display("FAIL prio_bus_req c%0d got %b want %b", i, bus_req, e_req);
         end
         checks++;
         if (data_data_ok !== e_dok || inst_data_ok !== e_iok) begin
            errors++;
            $display("FAIL prio_ok c%0d got d%b i%b want d%b i%b", i, data_data_ok, inst_data_ok, e_dok, e_iok);
         end
         checks++;
         if (stallreq_mem !== (i <= 2) || stallreq_if !== (i <= 6)) begin
            errors++;
            $display("FAIL prio_stall c%0d got m%b i%b", i, stallreq_mem, stallreq_if);
         end
         if (i == 1) begin
            checks++;
            if (bus_wr !== 1'b1 || bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h8000_1000 || bus_size !== 2'd2) begin
               errors++;
               $display("FAIL prio_store got %b/%h/%h/%0d want 1/deadbeef/80001000/2", bus_wr, bus_wdata, bus_addr, bus_size);
            end
         end
         if (i == 5) begin
            checks++;
            if (bus_wr !== 1'b0 || bus_addr !== 32'hBFC0_0004) begin
               errors++;
               $display("FAIL prio_fetch got %b/%h want 0/bfc00004", bus_wr, bus_addr);
            end
         end
         if (e_iok) begin
            checks++;
            if (inst_rdata !== 32'h8C02_0000) begin
               errors++;
               $display("FAIL prio_rdata got %h want 8c020000", inst_rdata);
            end
         end
      end
   endtask

   task automatic test_streak();
      logic e_iok, e_dok;
      s_aw = 0;
      s_dw = 0;
      for (int i = 0; i < 17; i++) begin
         step();
         if (i == 0) begin
            inst_req  = 1'b1;
            inst_addr = 32'hBFC0_0100;
            data_req  = 1'b1;
            data_wr   = 1'b0;
            data_size = 2'd2;
            data_addr = 32'h8000_0000;
         end
         if (i == 4) data_addr = 32'h8000_0004;
         if (i == 8) data_addr = 32'h8000_0008;
         if (i == 12) inst_addr = 32'hBFC0_0104;
         if (i == 16) begin
            inst_req = 1'b0;
            data_req = 1'b0;
         end
         @(negedge clk);
         e_dok = (i == 3) || (i == 7) || (i == 15);
         e_iok = (i == 11);
         checks++;
         if (data_data_ok !== e_dok || inst_data_ok !== e_iok) begin
            errors++;
            $display("FAIL streak_order c%0d got d%b i%b want d%b i%b", i, data_data_ok, inst_data_ok, e_dok, e_iok);
         end
         if (i == 9) begin
            checks++;
            if (bus_addr !== 32'hBFC0_0100) begin
               errors++;
               $display("FAIL streak_inst_addr got %h want bfc00100", bus_addr);
            end
         end
         if (i == 13) begin
            checks++;
            if (bus_addr !== 32'h8000_0008) begin
               errors++;
               $display("FAIL streak_clear_addr got %h want 80000008", bus_addr);
            end
         end
      end
   endtask

   task automatic test_flush();
      logic e_req, e_ok;
      s_aw = 0;
      s_dw = 2;
      s_rd = 32'h0BAD_0BAD;
      for (int i = 0; i < 12; i++) begin
         step();
         if (i == 0) begin
            inst_req  = 1'b1;
            inst_addr = 32'hBFC0_0010;
            flush     = 1'b1;
         end
         if (i == 1) flush = 1'b0;
         if (i == 3) flush = 1'b1;
         if (i == 4) flush = 1'b0;
         if (i == 7) begin
            s_dw = 0;
            s_rd = 32'h3C1D_8000;
         end
         if (i == 10) flush = 1'b1;
         if (i == 11) begin
            flush    = 1'b0;
            inst_req = 1'b0;
         end
         @(negedge clk);
         e_req = (i == 2) || (i == 8);
         e_ok  = (i == 10);
         checks++;
         if (bus_req !== e_req) begin
            errors++;
            $display("FAIL flush_bus_req c%0d got %b want %b", i, bus_req, e_req);
         end
         checks++;
         if (inst_data_ok !== e_ok) begin
            errors++;
            $display("FAIL flush_ok c%0d got %b want %b", i, inst_data_ok, e_ok);
         end
         checks++;
         if (stallreq_if !== (i <= 9)) begin
            errors++;
            $display("FAIL flush_stall c%0d got %b want %b", i, stallreq_if, (i <= 9));
         end
         if (e_ok) begin
            checks++;
            if (inst_rdata !== 32'h3C1D_8000) begin
               errors++;
               $display("FAIL flush_rdata got %h want 3c1d8000", inst_rdata);
            end
         end
      end
   endtask

   task automatic test_addr_wait();
      logic e_req, e_ok;
      s_aw = 3;
      s_dw = 0;
      s_rd = 32'h5A5A_1234;
      for (int i = 0; i < 9; i++) begin
         step();
         if (i == 0) begin
            data_req  = 1'b1;
            data_wr   = 1'b0;
            data_size = 2'd1;
            data_addr = 32'h8000_2002;
         end
         if (i == 7) data_req = 1'b0;
         @(negedge clk);
         e_req = (i >= 1) && (i <= 4);
         e_ok  = (i == 6);
         checks++;
         if (bus_req !== e_req) begin
            errors++;
            $display("FAIL wait_bus_req c%0d got %b want %b", i, bus_req, e_req);
         end
         checks++;
         if (data_data_ok !== e_ok) begin
            errors++;
            $display("FAIL wait_ok c%0d got %b want %b", i, data_data_ok, e_ok);
         end
         if (e_req) begin
            checks++;
            if (bus_addr !== 32'h8000_2002 || bus_size !== 2'd1 || bus_wr !== 1'b0) begin
               errors++;
               $display("FAIL wait_fields c%0d got %h/%0d/%b", i, bus_addr, bus_size, bus_wr);
            end
         end
         if (e_ok) begin
            checks++;
            if (data_rdata !== 32'h5A5A_1234) begin
               errors++;
               $display("FAIL wait_rdata got %h want 5a5a1234", data_rdata);
            end
         end
      end
      s_aw = 0;
   endtask

   task automatic test_rst_mid();
      logic e_req, e_ok, e_sif;
      s_aw = 0;
      s_dw = 3;
      for (int i = 0; i < 9; i++) begin
         step();
         if (i == 0) begin
            inst_req  = 1'b1;
            inst_addr = 32'hBFC0_0020;
         end
         if (i == 2) begin
            rst      = 1'b0;
            inst_req = 1'b0;
         end
         if (i == 3) begin
            rst         = 1'b1;
            s_ph        = 1'b0;
            s_cnt       = 0;
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            s_dw        = 0;
            s_rd        = 32'h2409_0002;
         end
         if (i == 4) begin
            inst_req  = 1'b1;
            inst_addr = 32'hBFC0_0024;
         end
         if (i == 8) inst_req = 1'b0;
         @(negedge clk);
         e_req = (i == 1) || (i == 5);
         e_ok  = (i == 7);
         e_sif = (i <= 1) || ((i >= 4) && (i <= 6));
         checks++;
         if (bus_req !== e_req) begin
            errors++;
            $display("FAIL rstmid_bus_req c%0d got %b want %b", i, bus_req, e_req);
         end
         checks++;
         if (inst_data_ok !== e_ok || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ok c%0d got i%b d%b want i%b d0", i, inst_data_ok, data_data_ok, e_ok);
         end
         checks++;
         if (stallreq_if !== e_sif || stallreq_mem !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stall c%0d got %b%b want %b0", i, stallreq_if, stallreq_mem, e_sif);
         end
         if (i == 3) begin
            checks++;
            if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
               errors++;
               $display("FAIL rstmid_rdata got %h/%h want 0", inst_rdata, data_rdata);
            end
         end
         if (e_ok) begin
            checks++;
            if (inst_rdata !== 32'h2409_0002) begin
               errors++;
               $display("FAIL rstmid_new_rdata got %h want 24090002", inst_rdata);
            end
         end
      end
   endtask

   // Timeline model: a grant at cycle g with a/d slave waits puts bus_req
   // on g+1..g+1+a, the completion pulse at g+3+a+d, and frees the bus
   // at g+4+a+d.
   task automatic test_random();
      bit          i_act = 1'b0;
      bit          d_act = 1'b0;
      bit          p_iok = 1'b0;
      bit          p_dok = 1'b0;
      bit          busy = 1'b0;
      bit          m_port = 1'b0;
      bit          m_disc = 1'b0;
      bit          m_wr = 1'b0;
      bit          gd, gi, e_breq, e_iok, e_dok, e_sif, e_smem;
      int          g = 0;
      int          m_aw = 0;
      int          m_dw = 0;
      int          t;
      int          streak = 0;
      logic [1:0]  m_size = 2'd0;
      logic [31:0] m_addr = 32'h0;
      logic [31:0] m_wdata = 32'h0;
      logic [31:0] m_rd = 32'h0;
      for (int c = 0; c < 400; c++) begin
         step();
         if (p_iok) i_act = 1'b0;
         if (p_dok) d_act = 1'b0;
         if (!i_act && $urandom_range(0, 2) != 0) begin
            i_act     = 1'b1;
            inst_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_act && $urandom_range(0, 1) == 0) begin
            d_act      = 1'b1;
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wdata = $urandom;
         end
         inst_req = i_act;
         data_req = d_act;
         flush    = ($urandom_range(0, 7) == 0);
         e_breq = 1'b0;
         e_iok  = 1'b0;
         e_dok  = 1'b0;
         if (busy && c == g + 4 + m_aw + m_dw) busy = 1'b0;
         if (!busy) begin
            gd = d_act && !(i_act && streak == 2);
            gi = i_act && !gd && !flush;
            if (gd || gi) begin
               busy   = 1'b1;
               g      = c;
               m_port = gd;
               m_disc = 1'b0;
               m_aw   = $urandom_range(0, 2);
               m_dw   = $urandom_range(0, 2);
               m_rd   = $urandom;
               s_aw   = m_aw;
               s_dw   = m_dw;
               s_rd   = m_rd;
               if (gd) begin
                  m_addr  = data_addr;
                  m_wr    = data_wr;
                  m_size  = data_size;
                  m_wdata = data_wdata;
                  if (i_act && streak < 2) streak++;
               end else begin
                  m_addr = inst_addr;
                  m_wr   = 1'b0;
                  m_size = 2'd2;
                  streak = 0;
               end
            end
         end else begin
            t = c - g;
            e_breq = (t >= 1) && (t <= 1 + m_aw);
            if (!m_port && flush && t >= 1 && t <= 2 + m_aw + m_dw) m_disc = 1'b1;
            if (t == 3 + m_aw + m_dw) begin
               e_iok = !m_port && !m_disc;
               e_dok = m_port;
            end
         end
         e_sif  = i_act && !e_iok;
         e_smem = d_act && !e_dok;
         @(negedge clk);
         checks++;
         if (bus_req !== e_breq) begin
            errors++;
            $display("FAIL rand_bus_req c%0d got %b want %b", c, bus_req, e_breq);
         end
         checks++;
         if (inst_data_ok !== e_iok || data_data_ok !== e_dok) begin
            errors++;
            $display("FAIL rand_ok c%0d got i%b d%b want i%b d%b", c, inst_data_ok, data_data_ok, e_iok, e_dok);
         end
         checks++;
         if (stallreq_if !== e_sif || stallreq_mem !== e_smem) begin
            errors++;
            $display("FAIL rand_stall c%0d got %b%b want %b%b", c, stallreq_if, stallreq_mem, e_sif, e_smem);
         end
         if (e_breq) begin
            checks++;
            if (bus_addr !== m_addr || bus_wr !== m_wr || bus_size !== m_size) begin
               errors++;
               $display("FAIL rand_fields c%0d got %h/%b/%0d want %h/%b/%0d", c, bus_addr, bus_wr, bus_size, m_addr, m_wr, m_size);
            end
            if (m_port && m_wr) begin
               checks++;
               if (bus_wdata !== m_wdata) begin
                  errors++;
                  $display("FAIL rand_wdata c%0d got %h want %h", c, bus_wdata, m_wdata);
               end
            end
         end
         if (e_iok) begin
            checks++;
            if (inst_rdata !== m_rd) begin
               errors++;
               $display("FAIL rand_irdata c%0d got %h want %h", c, inst_rdata, m_rd);
            end
         end
         if (e_dok) begin
            checks++;
            if (data_rdata !== m_rd) begin
               errors++;
               $display("FAIL rand_drdata c%0d got %h want %h", c, data_rdata, m_rd);
            end
         end
         p_iok = e_iok;
         p_dok = e_dok;
      end
      inst_req = 1'b0;
      data_req = 1'b0;
      flush    = 1'b0;
   endtask

   initial begin
      rst         = 1'b0;
      inst_req    = 1'b0;
      inst_addr   = 32'h0;
      data_req    = 1'b0;
      data_wr     = 1'b0;
      data_size   = 2'd0;
      data_addr   = 32'h0;
      data_wdata  = 32'h0;
      flush       = 1'b0;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = 32'h0;
      test_reset();
      test_single_fetch();
      test_priority();
      test_streak();
      test_flush();
      test_addr_wait();
      test_rst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
